// File: rtl/route_data_stream_if.sv
// Drain-side handshake bundle between the lane buffer and the LUT input.
interface route_data_stream_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/route_data_stream.sv
// Intermediate lane buffer: bulk load from M1, addressed feedback writes,
// latency-1 random reads and a valid/ready drain of all lanes to the LUT.
module route_data_stream #(
    parameter int LANES  = 10,
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [LANES*WIDTH-1:0] m1_result,
    input  logic                   bulk_load,
    input  logic                   fb_valid,
    input  logic [ADDR_W-1:0]      fb_addr,
    input  logic [WIDTH-1:0]       fb_data,
    input  logic                   rd_en,
    input  logic [ADDR_W-1:0]      rd_addr,
    input  logic                   drain_start,
    input  logic [WIDTH-1:0]       sram_data,
    input  logic                   data_out_sel,
    input  logic                   err_clr,
    route_data_stream_if.master    lut,
    output logic [WIDTH-1:0]       lut_data,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    localparam logic [ADDR_W:0]   LANES_X = (ADDR_W+1)'(LANES);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(LANES - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [WIDTH-1:0]  out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              done_q, done_d;
    logic              err_q, err_d, err_set;
    logic [WIDTH-1:0]  lane_q [LANES];

    logic              fb_ok, rd_ok, bulk_we, fb_we, drain_go;
    logic [ADDR_W-1:0] sel_addr;
    logic [WIDTH-1:0]  fwd_word;

    assign fb_ok    = {1'b0, fb_addr} < LANES_X;
    assign rd_ok    = {1'b0, rd_addr} < LANES_X;
    assign bulk_we  = (state_q == IDLE) && bulk_load;
    assign fb_we    = fb_valid && fb_ok && !bulk_we;
    assign drain_go = (state_q == IDLE) && drain_start && !bulk_load;

    // Source lane for the next out_data word, with same-cycle feedback forwarding.
    always_comb begin
        sel_addr = '0;
        if (state_q == DRAIN)
            sel_addr = ptr_q + ADDR_W'(1);
        else if (!drain_go)
            sel_addr = rd_addr;
        fwd_word = (fb_we && (fb_addr == sel_addr)) ? fb_data : lane_q[sel_addr];
    end

    // Lane storage: bulk load wins over feedback writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < LANES; i++)
                lane_q[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < LANES; i++) begin
                if (bulk_we)
                    lane_q[i] <= m1_result[i*WIDTH +: WIDTH];
                else if (fb_we && (fb_addr == ADDR_W'(i)))
                    lane_q[i] <= fb_data;
            end
        end
    end

    // State, pointer, output and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    // Next-state, drain sequencing, random reads and error detection.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        done_d      = 1'b0;
        err_set     = 1'b0;

        case (state_q)
            IDLE: begin
                if (fb_valid && !bulk_load && !fb_ok)
                    err_set = 1'b1;
                if (drain_go) begin
                    out_data_d  = fwd_word;
                    ptr_d       = '0;
                    out_valid_d = 1'b1;
                    state_d     = DRAIN;
                end else if (rd_en) begin
                    if (rd_ok)
                        out_data_d = fwd_word;
                    else
                        err_set = 1'b1;
                end
            end
            DRAIN: begin
                if (bulk_load)
                    err_set = 1'b1;
                if (fb_valid && !fb_ok)
                    err_set = 1'b1;
                if (out_valid_q && lut.out_ready) begin
                    if (ptr_q == LAST) begin
                        out_valid_d = 1'b0;
                        ptr_d       = '0;
                        state_d     = IDLE;
                        done_d      = 1'b1;
                    end else begin
                        ptr_d      = ptr_q + ADDR_W'(1);
                        out_data_d = fwd_word;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (err_set)
            err_d = 1'b1;
        else if (err_clr)
            err_d = 1'b0;
        else
            err_d = err_q;
    end

    assign lut.out_data  = out_data_q;
    assign lut.out_valid = out_valid_q;
    assign lut_data      = data_out_sel ? sram_data : out_data_q;
    assign busy          = (state_q == DRAIN);
    assign done          = done_q;
    assign err           = err_q;

endmodule

// File: tb/tb_route_data_stream.sv
// Directed self-checking bench for route_data_stream.
module tb_route_data_stream;

    localparam int LANES  = 10;
    localparam int WIDTH  = 16;
    localparam int ADDR_W = 4;

    logic                   clk;
    logic                   rst_n;
    logic [LANES*WIDTH-1:0] m1_result;
    logic                   bulk_load;
    logic                   fb_valid;
    logic [ADDR_W-1:0]      fb_addr;
    logic [WIDTH-1:0]       fb_data;
    logic                   rd_en;
    logic [ADDR_W-1:0]      rd_addr;
    logic                   drain_start;
    logic [WIDTH-1:0]       sram_data;
    logic                   data_out_sel;
    logic                   err_clr;
    logic [WIDTH-1:0]       lut_data;
    logic                   busy;
    logic                   done;
    logic                   err;

    int n_cmp = 0;
    int n_bad = 0;

    route_data_stream_if #(.WIDTH(WIDTH)) lut ();

    route_data_stream #(
        .LANES (LANES),
        .WIDTH (WIDTH),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .m1_result   (m1_result),
        .bulk_load   (bulk_load),
        .fb_valid    (fb_valid),
        .fb_addr     (fb_addr),
        .fb_data     (fb_data),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .drain_start (drain_start),
        .sram_data   (sram_data),
        .data_out_sel(data_out_sel),
        .err_clr     (err_clr),
        .lut         (lut.master),
        .lut_data    (lut_data),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_pattern(input logic [15:0] base);
        for (int i = 0; i < LANES; i++)
            m1_result[i*WIDTH +: WIDTH] = base + 16'(i);
        bulk_load = 1'b1;
        tick();
        bulk_load = 1'b0;
    endtask

    task automatic read_lane(input logic [ADDR_W-1:0] a, input logic [15:0] exp, input string tag);
        rd_en   = 1'b1;
        rd_addr = a;
        tick();
        rd_en   = 1'b0;
        chk(tag, 32'(lut.out_data), 32'(exp));
    endtask

    initial begin
        int          hs;
        int          cyc;
        logic        stalled;
        logic [15:0] held;

        rst_n = 1'b0; m1_result = '0; bulk_load = 1'b0; fb_valid = 1'b0;
        fb_addr = '0; fb_data = '0; rd_en = 1'b0; rd_addr = '0;
        drain_start = 1'b0; sram_data = '0; data_out_sel = 1'b0; err_clr = 1'b0;
        lut.out_ready = 1'b0;
        repeat (2) tick();
        chk("rst_out_data", 32'(lut.out_data), 32'h0);
        chk("rst_out_valid", 32'(lut.out_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        #4 rst_n = 1'b1;
        tick();

        // Bulk load and latency-1 random read.
        load_pattern(16'h0100);
        read_lane(4'd3, 16'h0103, "rd_lane3");
        chk("rd_lane3_err", 32'(err), 32'h0);
        chk("lut_sel0", 32'(lut_data), 32'h0103);

        // Feedback write forwarded to a same-cycle read of the same lane.
        fb_valid = 1'b1; fb_addr = 4'd9; fb_data = 16'hBEEF;
        rd_en = 1'b1; rd_addr = 4'd9;
        tick();
        fb_valid = 1'b0; rd_en = 1'b0;
        chk("fwd_lane9", 32'(lut.out_data), 32'hBEEF);
        read_lane(4'd0, 16'h0100, "rd_lane0");
        read_lane(4'd9, 16'hBEEF, "rd_lane9_stored");

        // Full drain with random back-pressure.
        load_pattern(16'h0100);
        drain_start = 1'b1;
        tick();
        drain_start = 1'b0;
        chk("drain_busy", 32'(busy), 32'h1);
        chk("drain_valid", 32'(lut.out_valid), 32'h1);
        hs = 0; cyc = 0; stalled = 1'b0; held = '0;
        while (hs < LANES && cyc < 400) begin
            lut.out_ready = 1'($urandom_range(0, 1));
            if (lut.out_ready && lut.out_valid) begin
                chk("drain_word", 32'(lut.out_data), 32'h0100 + 32'(hs));
                hs++;
                stalled = 1'b0;
            end else begin
                stalled = 1'b1;
                held    = lut.out_data;
            end
            tick();
            cyc++;
            if (stalled)
                chk("drain_stall_hold", 32'(lut.out_data), 32'(held));
            chk("drain_done", 32'(done), (hs == LANES) ? 32'h1 : 32'h0);
        end
        lut.out_ready = 1'b0;
        chk("drain_count", 32'(hs), 32'(LANES));
        chk("drain_end_busy", 32'(busy), 32'h0);
        chk("drain_end_valid", 32'(lut.out_valid), 32'h0);
        tick();
        chk("done_single", 32'(done), 32'h0);

        // Feedback into the next lane on a handshake, bulk_load mid-drain.
        load_pattern(16'h0100);
        drain_start = 1'b1;
        tick();
        drain_start = 1'b0;
        lut.out_ready = 1'b1;
        repeat (4) tick();
        chk("mid_ptr4", 32'(lut.out_data), 32'h0104);
        fb_valid = 1'b1; fb_addr = 4'd5; fb_data = 16'h1234;
        tick();
        fb_valid = 1'b0; lut.out_ready = 1'b0;
        chk("mid_fwd_lane5", 32'(lut.out_data), 32'h1234);
        for (int i = 0; i < LANES; i++)
            m1_result[i*WIDTH +: WIDTH] = 16'h0200 + 16'(i);
        bulk_load = 1'b1;
        tick();
        bulk_load = 1'b0;
        chk("mid_bulk_err", 32'(err), 32'h1);
        chk("mid_bulk_hold", 32'(lut.out_data), 32'h1234);
        fb_valid = 1'b1; fb_addr = 4'd5; fb_data = 16'h5555;
        tick();
        fb_valid = 1'b0;
        chk("mid_fb_cur_lane", 32'(lut.out_data), 32'h1234);
        lut.out_ready = 1'b1;
        for (int i = 6; i < LANES; i++) begin
            tick();
            chk("mid_tail_word", 32'(lut.out_data), 32'h0100 + 32'(i));
        end
        tick();
        lut.out_ready = 1'b0;
        chk("mid_done", 32'(done), 32'h1);
        chk("mid_busy", 32'(busy), 32'h0);
        read_lane(4'd5, 16'h5555, "mid_lane5_stored");
        read_lane(4'd0, 16'h0100, "mid_lanes_unchanged");
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("err_clr", 32'(err), 32'h0);

        // Out-of-range feedback and read addresses.
        fb_valid = 1'b1; fb_addr = 4'd12; fb_data = 16'hDEAD;
        tick();
        fb_valid = 1'b0;
        chk("fb_oor_err", 32'(err), 32'h1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("err_clr2", 32'(err), 32'h0);
        read_lane(4'd2, 16'h0102, "rd_lane2");
        read_lane(4'd10, 16'h0102, "rd_oor_hold");
        chk("rd_oor_err", 32'(err), 32'h1);
        err_clr = 1'b1; rd_en = 1'b1; rd_addr = 4'd10;
        tick();
        err_clr = 1'b0; rd_en = 1'b0;
        chk("err_clr_vs_new", 32'(err), 32'h1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("err_clr3", 32'(err), 32'h0);

        // Asynchronous reset mid-drain at ptr 6.
        load_pattern(16'h0100);
        drain_start = 1'b1;
        tick();
        drain_start = 1'b0;
        lut.out_ready = 1'b1;
        repeat (6) tick();
        chk("abort_ptr6", 32'(lut.out_data), 32'h0106);
        rst_n = 1'b0;
        #1;
        chk("abort_valid", 32'(lut.out_valid), 32'h0);
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_done", 32'(done), 32'h0);
        tick();
        chk("abort_done_later", 32'(done), 32'h0);
        lut.out_ready = 1'b0;
        data_out_sel = 1'b1; sram_data = 16'hA5A5;
        #1;
        chk("lut_sram", 32'(lut_data), 32'hA5A5);
        data_out_sel = 1'b0;
        #1;
        chk("lut_buf", 32'(lut_data), 32'h0000);
        #2 rst_n = 1'b1;
        tick();
        read_lane(4'd4, 16'h0000, "abort_lane4");
        read_lane(4'd9, 16'h0000, "abort_lane9");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
